// File: rtl/lsu_port_if.sv
// lsu_port_if: request/response handshake and RAM bus of the load/store unit.
//   slave  modport : seen by lsu_port (takes requests, drives RAM strobes)
//   master modport : seen by the execute stage / RAM side (or a testbench)
//   req_*  : request channel (valid/ready, we, funct3, addr, wdata)
//   resp_* : response channel (valid/ready, rdata, error)
//   mem_*  : RAM byte address, write data, sb/sh/sw strobes, combinational read
interface lsu_port_if #(
  parameter int ADDRESS_LENGTH = 32
);
  logic                      req_valid;
  logic                      req_ready;
  logic                      req_we;
  logic [2:0]                req_funct3;
  logic [ADDRESS_LENGTH-1:0] req_addr;
  logic [ADDRESS_LENGTH-1:0] req_wdata;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [ADDRESS_LENGTH-1:0] resp_rdata;
  logic                      resp_error;

  logic [ADDRESS_LENGTH-1:0] mem_a;
  logic [ADDRESS_LENGTH-1:0] mem_wd;
  logic                      mem_sb;
  logic                      mem_sh;
  logic                      mem_sw;
  logic [ADDRESS_LENGTH-1:0] mem_rd;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_a, mem_wd, mem_sb, mem_sh, mem_sw
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_a, mem_wd, mem_sb, mem_sh, mem_sw
  );
endinterface

// File: rtl/lsu_port.sv
// lsu_port: single-outstanding load/store unit between execute and data RAM.
// Accepts one request, spends one ACCESS cycle driving the RAM (strobe for a
// store, read-word capture for a load), then holds one response until taken.
// Misaligned or illegal requests never touch memory and respond with error.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : lsu_port_if slave modport (request, response and RAM signals)
//
// state    | meaning
// ---------+--------------------------------------------------------
// S_IDLE   | req_ready high, waiting for a request
// S_ACCESS | one cycle: RAM strobe asserted / read word captured
// S_RESP   | resp_valid high, waiting for resp_ready
module lsu_port #(
  parameter int ADDRESS_LENGTH = 32
) (
  input logic       clk,
  input logic       rst_n,
  lsu_port_if.slave bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [1:0]                state;
  logic                      we_q;
  logic [2:0]                funct3_q;
  logic                      err_q;
  logic [ADDRESS_LENGTH-1:0] addr_q;
  logic [ADDRESS_LENGTH-1:0] wdata_q;
  logic [ADDRESS_LENGTH-1:0] rdata_q;
  logic                      resp_err_q;
  logic [ADDRESS_LENGTH-1:0] load_ext;
  logic                      req_err;
  logic                      do_store;

  // Illegal width codes, unsigned stores, and misaligned half/word accesses.
  function automatic logic calc_err(input logic we, input logic [2:0] f3,
                                    input logic [1:0] a);
    logic e;
    case (f3)
      F3_B:         e = 1'b0;
      F3_H:         e = a[0];
      F3_W:         e = (a != 2'b00);
      F3_BU:        e = we;
      F3_HU:        e = we | a[0];
      default:      e = 1'b1;
    endcase
    return e;
  endfunction

  assign req_err = calc_err(bus.req_we, bus.req_funct3, bus.req_addr[1:0]);

  // mem_rd[7:0] is the byte at mem_a, so extension always works on the low bits.
  always_comb begin
    load_ext = '0;
    case (funct3_q)
      F3_B:    load_ext = {{(ADDRESS_LENGTH-8){bus.mem_rd[7]}}, bus.mem_rd[7:0]};
      F3_H:    load_ext = {{(ADDRESS_LENGTH-16){bus.mem_rd[15]}}, bus.mem_rd[15:0]};
      F3_W:    load_ext = bus.mem_rd;
      F3_BU:   load_ext = {{(ADDRESS_LENGTH-8){1'b0}}, bus.mem_rd[7:0]};
      F3_HU:   load_ext = {{(ADDRESS_LENGTH-16){1'b0}}, bus.mem_rd[15:0]};
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      resp_err_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            we_q     <= bus.req_we;
            funct3_q <= bus.req_funct3;
            err_q    <= req_err;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            state    <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          resp_err_q <= err_q;
          rdata_q    <= (!we_q && !err_q) ? load_ext : '0;
          state      <= S_RESP;
        end
        S_RESP: begin
          if (bus.resp_ready) begin
            resp_err_q <= 1'b0;
            rdata_q    <= '0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Gated by rst_n so a reset landing mid-ACCESS kills the write before the edge.
  assign do_store = rst_n && (state == S_ACCESS) && we_q && !err_q;

  assign bus.mem_sb     = do_store && (funct3_q == F3_B);
  assign bus.mem_sh     = do_store && (funct3_q == F3_H);
  assign bus.mem_sw     = do_store && (funct3_q == F3_W);
  assign bus.mem_a      = addr_q;
  assign bus.mem_wd     = wdata_q;
  assign bus.req_ready  = rst_n && (state == S_IDLE);
  assign bus.resp_valid = (state == S_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = resp_err_q;

endmodule
